fetch_unit: RTL and testbench

Multi-cycle instruction fetch unit for the LEGv8 single-cycle datapath. It owns the program counter and fetches 32-bit instructions from an instruction memory over a req/ack handshake. Each instruction is held stable and its opcode field is presented to the control decoder. When execution completes, the unit consumes the decoder's branch/uncond_branch outputs, the ALU zero flag and the extended immediate, and computes the next PC.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_next_pc.sv | 22 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the LEGv8 fetch unit: state encoding, instruction field
// positions and the opcode patterns also used by the control decoder.
package fetch_unit_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 21;
   localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
   localparam int unsigned RETIRED_W  = 32;
   localparam int unsigned PC_INC     = 4;

   // R/D-format opcodes are full 11-bit patterns; CB/B formats match on a prefix
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [5:0]  OPC_B    = 6'b000101;

   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake plus the decoder/datapath side.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W = 64
);
   logic                 imem_req;
   logic [PC_W-1:0]      imem_addr;
   logic                 imem_ack;
   logic [INSTR_W-1:0]   imem_data;
   logic [INSTR_W-1:0]   instr;
   logic [OPCODE_W-1:0]  opcode;
   logic                 instr_valid;
   logic                 instr_done;
   logic                 branch;
   logic                 uncond_branch;
   logic                 zero;
   logic [PC_W-1:0]      ext_imm;
   logic [PC_W-1:0]      pc;
   logic                 branch_taken;
   logic [RETIRED_W-1:0] retired;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_valid, pc, branch_taken, retired,
      input  imem_ack, imem_data, instr_done, branch, uncond_branch, zero, ext_imm
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_valid, pc, branch_taken, retired,
      output imem_ack, imem_data, instr_done, branch, uncond_branch, zero, ext_imm
   );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC: sequential PC+4 or word-scaled branch target.
module fetch_unit_next_pc
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W = 64
) (
   input  logic [PC_W-1:0] i_pc,
   input  logic [PC_W-1:0] i_ext_imm,
   input  logic            i_branch,
   input  logic            i_uncond_branch,
   input  logic            i_zero,
   output logic [PC_W-1:0] o_next_pc_c,
   output logic            o_taken_c
);

   // uncond_branch selects first so an unknown branch input cannot leak into B
   always_comb begin
      o_taken_c   = i_uncond_branch ? 1'b1 : (i_branch & i_zero);
      o_next_pc_c = o_taken_c ? (i_pc + (i_ext_imm << 2)) : (i_pc + PC_W'(PC_INC));
   end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle LEGv8 instruction fetch: owns the PC, fetches over req/ack,
// holds the instruction until the datapath retires it, then steps/branches.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     PC_W     = 64,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input logic          CLK,
   input logic          Reset,
   fetch_unit_if.master bus
);

   logic [1:0]           r_state;
   logic [PC_W-1:0]      r_pc;
   logic [INSTR_W-1:0]   r_instr;
   logic                 r_req;
   logic                 r_valid;
   logic                 r_taken;
   logic [RETIRED_W-1:0] r_retired;

   logic [1:0]           w_state_nx;
   logic                 w_req_nx;
   logic                 w_valid_nx;
   logic                 w_taken_nx;
   logic                 w_capture;
   logic                 w_retire;
   logic [PC_W-1:0]      w_next_pc;
   logic                 w_taken;

   fetch_unit_next_pc #(.PC_W(PC_W)) u_next_pc (
      .i_pc            (r_pc),
      .i_ext_imm       (bus.ext_imm),
      .i_branch        (bus.branch),
      .i_uncond_branch (bus.uncond_branch),
      .i_zero          (bus.zero),
      .o_next_pc_c     (w_next_pc),
      .o_taken_c       (w_taken)
   );

   // Next-state and next-output decode; req/valid are registered one state ahead
   always_comb begin
      w_state_nx = r_state;
      w_req_nx   = 1'b0;
      w_valid_nx = 1'b0;
      w_taken_nx = 1'b0;
      w_capture  = 1'b0;
      w_retire   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nx = S_FETCH;
            w_req_nx   = 1'b1;
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               w_capture  = 1'b1;
               w_state_nx = S_HOLD;
               w_valid_nx = 1'b1;
            end else begin
               w_req_nx = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.instr_done) begin
               w_retire   = 1'b1;
               w_taken_nx = w_taken;
               w_state_nx = S_FETCH;
               w_req_nx   = 1'b1;
            end else begin
               w_valid_nx = 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_pc      <= START_PC;
         r_instr   <= '0;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_taken   <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_state_nx;
         r_req   <= w_req_nx;
         r_valid <= w_valid_nx;
         r_taken <= w_taken_nx;
         if (w_capture) begin
            r_instr <= bus.imem_data;
         end
         if (w_retire) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + RETIRED_W'(1);
         end
      end
   end

   assign bus.imem_req     = r_req;
   assign bus.imem_addr    = r_pc;
   assign bus.pc           = r_pc;
   assign bus.instr        = r_instr;
   assign bus.opcode       = opcode_of(r_instr);
   assign bus.instr_valid  = r_valid;
   assign bus.branch_taken = r_taken;
   assign bus.retired      = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver queues expected fetch addresses,
// instructions and retirements; a monitor checks them as the DUT presents them.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   typedef struct {
      logic [63:0] pc;
      logic        tk;
      logic [31:0] ret;
   } ret_t;

   logic [63:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   ret_t        exp_ret_q[$];

   fetch_unit_if #(.PC_W(64)) bus ();

   fetch_unit #(.PC_W(64), .START_PC(64'h0)) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event want none", name);
   endtask

   // Monitor: sampled 1 time unit after the active edge
   logic        prev_req = 1'b0;
   logic        prev_valid = 1'b0;
   logic [63:0] held_addr;
   logic [31:0] held_instr;
   logic [31:0] w;
   ret_t        r;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_req   = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (bus.imem_req) begin
            if (!prev_req) begin
               if (exp_addr_q.size() == 0) flag("unexpected_req");
               else begin
                  held_addr = exp_addr_q.pop_front();
                  check("fetch_addr", bus.imem_addr, held_addr);
                  check("fetch_pc", bus.pc, held_addr);
               end
            end else begin
               check("addr_stable", bus.imem_addr, held_addr);
            end
         end
         if (bus.instr_valid) begin
            if (!prev_valid) begin
               if (exp_instr_q.size() == 0) flag("unexpected_valid");
               else begin
                  w = exp_instr_q.pop_front();
                  held_instr = w;
                  check("instr", 64'(bus.instr), 64'(w));
                  check("opcode", 64'(bus.opcode), 64'(w[31:21]));
               end
            end else begin
               check("instr_stable", 64'(bus.instr), 64'(held_instr));
               check("opcode_stable", 64'(bus.opcode), 64'(held_instr[31:21]));
            end
         end
         if (prev_valid && !bus.instr_valid) begin
            if (exp_ret_q.size() == 0) flag("unexpected_retire");
            else begin
               r = exp_ret_q.pop_front();
               check("next_pc", bus.pc, r.pc);
               check("branch_taken", 64'(bus.branch_taken), 64'(r.tk));
               check("retired", 64'(bus.retired), 64'(r.ret));
            end
         end else begin
            check("taken_idle", 64'(bus.branch_taken), 64'd0);
         end
         prev_req   = bus.imem_req;
         prev_valid = bus.instr_valid;
      end
   end

   task automatic wait_req();
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", 64'(bus.imem_req), 64'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (bus.instr_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("valid_seen", 64'(bus.instr_valid), 64'd1);
   endtask

   // Acks after ack_dly cycles, holding a bogus done/B request meanwhile
   task automatic do_fetch(input logic [31:0] word, input int ack_dly);
      wait_req();
      for (int i = 0; i < ack_dly; i++) begin
         bus.instr_done    = 1'b1;
         bus.uncond_branch = 1'b1;
         bus.ext_imm       = 64'h40;
         @(negedge clk);
      end
      bus.instr_done    = 1'b0;
      bus.uncond_branch = 1'b0;
      bus.imem_ack      = 1'b1;
      bus.imem_data     = word;
      exp_instr_q.push_back(word);
      @(negedge clk);
      bus.imem_ack  = 1'b0;
      bus.imem_data = ~word;
   endtask

   // Retires after done_dly cycles, pulsing bogus acks meanwhile
   task automatic do_exec(input int done_dly, input logic br, input logic ub, input logic z,
                          input logic [63:0] imm, input logic [63:0] exp_pc,
                          input logic exp_tk, input logic [31:0] exp_ret);
      ret_t e;
      wait_valid();
      for (int i = 0; i < done_dly; i++) begin
         bus.imem_ack  = 1'b1;
         bus.imem_data = 32'hDEAD_BEEF;
         @(negedge clk);
      end
      bus.imem_ack      = 1'b0;
      bus.instr_done    = 1'b1;
      bus.branch        = br;
      bus.uncond_branch = ub;
      bus.zero          = z;
      bus.ext_imm       = imm;
      e.pc  = exp_pc;
      e.tk  = exp_tk;
      e.ret = exp_ret;
      exp_ret_q.push_back(e);
      exp_addr_q.push_back(exp_pc);
      @(negedge clk);
      bus.instr_done    = 1'b0;
      bus.branch        = 1'b1;
      bus.uncond_branch = 1'b0;
      bus.zero          = 1'b1;
      bus.ext_imm       = 64'h7;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   int c0;

   initial begin
      bus.imem_ack      = 1'b0;
      bus.imem_data     = 32'h0;
      bus.instr_done    = 1'b0;
      bus.branch        = 1'b0;
      bus.uncond_branch = 1'b0;
      bus.zero          = 1'b0;
      bus.ext_imm       = 64'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req", 64'(bus.imem_req), 64'd0);
      check("rst_valid", 64'(bus.instr_valid), 64'd0);
      check("rst_pc", bus.pc, 64'h0);
      check("rst_instr", 64'(bus.instr), 64'h0);
      check("rst_opcode", 64'(bus.opcode), 64'h0);
      check("rst_taken", 64'(bus.branch_taken), 64'd0);
      check("rst_retired", 64'(bus.retired), 64'd0);
      exp_addr_q.push_back(64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("first_req_latency", 64'(bus.imem_req), 64'd1);

      // Straight-line: three instructions in six cycles
      c0 = cyc;
      do_fetch(32'h8B02_0020, 0); do_exec(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4, 1'b0, 32'd1);
      do_fetch(32'hF840_0041, 0); do_exec(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h8, 1'b0, 32'd2);
      do_fetch(32'hCB03_0062, 0); do_exec(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'hC, 1'b0, 32'd3);
      check("three_instr_cycles", 64'(cyc - c0), 64'd6);
      do_fetch(32'h8A04_0083, 0); do_exec(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h10, 1'b0, 32'd4);

      // CBZ taken at 0x10, B back to 0x10, CBZ not taken, B forward to 0x20
      do_fetch(32'hB400_0060, 0); do_exec(0, 1'b1, 1'b0, 1'b1, 64'd3, 64'h1C, 1'b1, 32'd5);
      do_fetch(32'h17FF_FFFD, 0);
      do_exec(0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h10, 1'b1, 32'd6);
      do_fetch(32'hB400_0060, 0); do_exec(0, 1'b1, 1'b0, 1'b0, 64'd3, 64'h14, 1'b0, 32'd7);
      do_fetch(32'h1400_0003, 0); do_exec(0, 1'b0, 1'b1, 1'b0, 64'd3, 64'h20, 1'b1, 32'd8);

      // B with unknown branch input
      do_fetch(32'h17FF_FFFE, 0);
      do_exec(0, 1'bx, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h18, 1'b1, 32'd9);

      // Slow memory and slow datapath with spurious strobes
      do_fetch(32'hAA05_0104, 5); do_exec(3, 1'b0, 1'b0, 1'b0, 64'h0, 64'h1C, 1'b0, 32'd10);

      // Reset while the fetch of 0x1C is pending; the later ack lands in S_IDLE
      @(negedge clk);
      check("fetch_pending", 64'(bus.imem_req), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_req", 64'(bus.imem_req), 64'd0);
      check("rst_mid_pc", bus.pc, 64'h0);
      exp_addr_q.push_back(64'h0);
      rst = 1'b0;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'hBAD0_0BAD;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("rst_refetch_req", 64'(bus.imem_req), 64'd1);
      check("rst_refetch_addr", bus.imem_addr, 64'h0);
      check("rst_ack_ignored_valid", 64'(bus.instr_valid), 64'd0);
      check("rst_ack_ignored_instr", 64'(bus.instr), 64'h0);
      check("rst_mid_retired", 64'(bus.retired), 64'd0);

      // Wrap-around: B to 2^64-4, then sequential step with retired at max
      do_fetch(32'hF800_0041, 0); do_exec(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h4, 1'b0, 32'd1);
      do_fetch(32'h17FF_FFFE, 0);
      do_exec(0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'd2);
      do_fetch(32'h8B02_0020, 0);
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      do_exec(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 32'd0);

      repeat (3) @(negedge clk);
      check("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
      check("instr_q_drained", 64'(exp_instr_q.size()), 64'd0);
      check("ret_q_drained", 64'(exp_ret_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
